// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
// Signed MULT/DIV handling is built only when MULDIV_SIGNED_EN is defined.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] inp1,
   input  logic [WIDTH-1:0] inp2,
   input  logic             cancel,
   input  logic             wrHi,
   input  logic             wrLo,
   input  logic [WIDTH-1:0] wrData,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_orig1;
   logic               r_div;

   logic [WIDTH-1:0]   w_m1;
   logic [WIDTH-1:0]   w_m2;
   logic [WIDTH:0]     w_madd;
   logic [WIDTH:0]     w_trial;
   logic [2*WIDTH-1:0] w_step;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;

`ifdef MULDIV_SIGNED_EN
   logic r_s1;
   logic r_s2;
   logic w_s1;
   logic w_s2;

   always_comb begin
      w_s1 = ~op[0] & inp1[WIDTH-1];
      w_s2 = ~op[0] & inp2[WIDTH-1];
      w_m1 = w_s1 ? (~inp1 + 1'b1) : inp1;
      w_m2 = w_s2 ? (~inp2 + 1'b1) : inp2;
   end
`else
   logic w_unused_op;

   assign w_unused_op = op[0];
   assign w_m1 = inp1;
   assign w_m2 = inp2;
`endif

   // Multiply: product accumulates in the upper half while the multiplier shifts out of the lower half.
   // Divide: upper half is the partial remainder, lower half shifts dividend bits out and quotient bits in.
   always_comb begin
      w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
      w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
      if (r_div) begin
         if (w_trial[WIDTH])
            w_step = {r_acc[2*WIDTH-2:0], 1'b0};
         else
            w_step = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
         w_step = {w_madd, r_acc[WIDTH-1:1]};
      end
   end

   always_comb begin
      w_res_hi = r_acc[2*WIDTH-1:WIDTH];
      w_res_lo = r_acc[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
      if (r_div) begin
         if (r_s1 ^ r_s2)
            w_res_lo = -r_acc[WIDTH-1:0];
         if (r_s1)
            w_res_hi = -r_acc[2*WIDTH-1:WIDTH];
      end else if (r_s1 ^ r_s2) begin
         {w_res_hi, w_res_lo} = -r_acc;
      end
`endif
      if (r_div && (r_b == '0)) begin
         w_res_lo = '1;
         w_res_hi = r_orig1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_acc   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_orig1 <= '0;
         r_div   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (wrHi)
                  r_hi <= wrData;
               if (wrLo)
                  r_lo <= wrData;
               if (start && !cancel) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_a     <= w_m1;
                  r_b     <= w_m2;
                  r_orig1 <= inp1;
                  r_div   <= op[1];
                  r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_m1 : w_m2)};
`ifdef MULDIV_SIGNED_EN
                  r_s1    <= w_s1;
                  r_s2    <= w_s2;
`endif
               end
            end
            S_RUN: begin
               if (cancel) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_acc <= w_step;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CW'(WIDTH - 1))
                     r_state <= S_FIX;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
               if (!cancel) begin
                  r_hi   <= w_res_hi;
                  r_lo   <= w_res_lo;
                  r_done <= 1'b1;
               end
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
